// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for a shared FIFO write port
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [IDX_W-1:0]   g;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   next_ptr;
  logic [3:0]         burst_cnt;
  logic               last_beat;
  logic               tenure_end;

  // First set request bit at or after position p, wrapping around.
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                            input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] w;
    logic [IDX_W-1:0] idx;
    logic             found;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(p) + k) % NUM_REQ);
      if (!found && r[idx]) begin
        found = 1'b1;
        w     = idx;
      end
    end
    return w;
  endfunction

  assign busy       = (state == GRANT);
  assign wr_en      = (state == GRANT) && req[g] && !full;
  assign ack        = wr_en ? gnt : '0;
  assign last_beat  = (({1'b0, burst_cnt} + 5'd1) == 5'(MAX_BURST));
  assign tenure_end = !req[g] || (wr_en && last_beat);
  assign next_ptr   = (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      g         <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= GRANT;
            g         <= pick(req, ptr);
            gnt       <= NUM_REQ'(1) << pick(req, ptr);
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          // Hand over straight to the next winner so the write port never idles.
          if (tenure_end) begin
            ptr       <= next_ptr;
            burst_cnt <= '0;
            if (|req) begin
              g   <= pick(req, next_ptr);
              gnt <= NUM_REQ'(1) << pick(req, next_ptr);
            end else begin
              state <= IDLE;
              gnt   <= '0;
            end
          end else if (wr_en) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed and randomized checks against a reference model
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic             full = 1'b0;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    ack;
  logic             wr_en;
  logic [DW-1:0]    wr_data;
  logic             busy;

  int n_chk = 0;
  int n_fail = 0;
  int own = -1;
  int ptr_m = 0;
  int cnt_m = 0;
  int wr_seen = 0;
  int mdl_wr[NR];
  int dut_ack[NR];
  logic [NR-1:0] m_ack = '0;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .full(full),
    .gnt(gnt), .ack(ack), .wr_en(wr_en), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick_m(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic step;
    logic [NR-1:0] e_gnt;
    logic [NR-1:0] e_ack;
    logic          e_wr;
    logic [DW-1:0] e_data;
    @(negedge clk);
    e_gnt  = (own < 0) ? '0 : NR'(1) << own;
    e_wr   = (own >= 0) && req[own] && !full;
    e_ack  = e_wr ? e_gnt : '0;
    e_data = (own < 0) ? '0 : req_data[own*DW +: DW];
    check_val("gnt", 32'(gnt), 32'(e_gnt));
    check_val("wr_en", 32'(wr_en), 32'(e_wr));
    check_val("ack", 32'(ack), 32'(e_ack));
    check_val("wr_data", 32'(wr_data), 32'(e_data));
    check_val("busy", 32'(busy), 32'(own >= 0));
    check_val("onehot0", 32'($onehot0(gnt)), 32'd1);
    check_val("no_wr_full", 32'(wr_en & full), 32'd0);
    for (int i = 0; i < NR; i++) begin
      dut_ack[i] += int'(ack[i]);
      if (e_wr && own == i) mdl_wr[i]++;
    end
    wr_seen += int'(wr_en);
    m_ack = e_ack;
    @(posedge clk);
    if (own < 0) begin
      if (req != '0) begin
        own   = pick_m(req, ptr_m);
        cnt_m = 0;
      end
    end else if (!req[own] || (e_wr && cnt_m + 1 == MB)) begin
      ptr_m = (own + 1) % NR;
      cnt_m = 0;
      own   = pick_m(req, ptr_m);
    end else if (e_wr) begin
      cnt_m++;
    end
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #1;
    check_val("rst_gnt", 32'(gnt), 32'd0);
    check_val("rst_ack", 32'(ack), 32'd0);
    check_val("rst_wr_en", 32'(wr_en), 32'd0);
    check_val("rst_wr_data", 32'(wr_data), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    own   = -1;
    ptr_m = 0;
    cnt_m = 0;
  endtask

  initial begin
    int w0;
    for (int i = 0; i < NR; i++) begin
      mdl_wr[i]  = 0;
      dut_ack[i] = 0;
    end
    #2;
    req = 4'b1111;
    do_reset();

    // Single requester, one-cycle grant latency.
    req = 4'b0100;
    req_data[2*DW +: DW] = 8'hA5;
    #1;
    check_val("t27_idle_gnt", 32'(gnt), 32'd0);
    step();
    check_val("t27_gnt", 32'(gnt), 32'h4);
    check_val("t27_wr_en", 32'(wr_en), 32'd1);
    check_val("t27_wr_data", 32'(wr_data), 32'hA5);
    check_val("t27_ack", 32'(ack), 32'h4);
    step();
    req = '0;
    step();
    step();

    // All requesting: 4-write bursts rotating 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    req_data = 32'h44332211;
    step();
    for (int c = 0; c < 20; c++) begin
      check_val("t28_gnt", 32'(gnt), 32'(1 << ((c / 4) % 4)));
      check_val("t28_wr_en", 32'(wr_en), 32'd1);
      step();
    end

    // Full stalls a burst without ending it.
    do_reset();
    req = 4'b0010;
    req_data = 32'h00003C00;
    step();
    w0 = wr_seen;
    step();
    step();
    full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_val("t29_gnt_hold", 32'(gnt), 32'h2);
      check_val("t29_wr_stall", 32'(wr_en), 32'd0);
      step();
    end
    full = 1'b0;
    step();
    step();
    check_val("t29_writes", 32'(wr_seen - w0), 32'd4);
    req = '0;
    step();
    step();

    // Granted requester drops early; pending requester 3 follows with no gap.
    do_reset();
    req = 4'b1001;
    req_data = 32'h77000055;
    step();
    check_val("t30_first", 32'(gnt), 32'h1);
    step();
    step();
    req = 4'b1000;
    #1;
    check_val("t30_drop_wr", 32'(wr_en), 32'd0);
    step();
    check_val("t30_handover", 32'(gnt), 32'h8);
    check_val("t30_wr_en", 32'(wr_en), 32'd1);
    step();
    req = '0;
    step();

    // Reset mid-burst, then arbitration restarts from pointer 0.
    do_reset();
    req = 4'b0100;
    req_data = 32'h00990000;
    step();
    step();
    do_reset();
    req = 4'b1100;
    req_data = 32'h88990000;
    #1;
    check_val("t31_idle", 32'(gnt), 32'd0);
    step();
    check_val("t31_gnt", 32'(gnt), 32'h4);
    check_val("t31_data", 32'(wr_data), 32'h99);

    // Randomized traffic and back-pressure.
    for (int i = 0; i < NR; i++) begin
      mdl_wr[i]  = 0;
      dut_ack[i] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (req[i]) begin
          if (m_ack[i]) begin
            if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
            req_data[i*DW +: DW] = DW'($urandom);
          end else if ($urandom_range(19, 0) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(9, 0) < 3) begin
          req[i] = 1'b1;
          req_data[i*DW +: DW] = DW'($urandom);
        end
      end
      full = ($urandom_range(4, 0) == 0);
      step();
    end
    for (int i = 0; i < NR; i++) check_val("ack_count", 32'(dut_ack[i]), 32'(mdl_wr[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
